// File: rtl/pipo_arb_pkg.sv
// Shared types and default parameters for the PIPO load arbiter.
package pipo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_HOLD_CYCLES = 3;

endpackage

// File: rtl/pipo_data_reg.sv
// Parallel-in/parallel-out holding register shared by all requesters.
module pipo_data_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture the word on load; otherwise keep the last loaded word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one requester's word into the shared
// PIPO register and holds it valid for HOLD_CYCLES cycles.
//
//   state | meaning
//   IDLE  | waiting; samples req_valid and picks the winner
//   LOAD  | one cycle; gnt to owner, register captures owner's word
//   HOLD  | q_valid high, counter runs HOLD_CYCLES-1 down to 0
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [WIDTH-1:0]         o_q,
  output logic                     o_q_valid,
  output logic [$clog2(N_REQ)-1:0] o_owner
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_pick;
  logic             w_any_req;
  logic             w_load;
  logic [WIDTH-1:0] w_din;

  // First requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_any_req = |i_req_valid;
  assign w_pick    = rr_pick(i_req_valid, r_ptr);
  assign w_din     = i_req_data[r_owner*WIDTH +: WIDTH];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = HOLD;
      HOLD:    if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from state and registered owner.
  always_comb begin
    o_gnt     = '0;
    w_load    = 1'b0;
    o_q_valid = 1'b0;
    case (r_state)
      LOAD: begin
        o_gnt[r_owner] = 1'b1;
        w_load         = 1'b1;
      end
      HOLD:    o_q_valid = 1'b1;
      default: ;
    endcase
  end

  // Winner/pointer capture on IDLE->LOAD and hold-window down-counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_owner <= w_pick;
        r_ptr   <= (w_pick == IDX_LAST) ? '0 : w_pick + IDX_W'(1);
      end
      if (r_state == LOAD) begin
        r_cnt <= CNT_INIT;
      end else if (r_state == HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_owner = r_owner;

  pipo_data_reg #(
    .WIDTH(WIDTH)
  ) u_data_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_din  (w_din),
    .o_q    (o_q)
  );

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a timeline-based reference model.
module tb_pipo_load_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int H1 = 3;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] gnt;
  logic [W-1:0]  q;
  logic          q_valid;
  logic [1:0]    owner;

  logic          rst2;
  logic [1:0]    rv2;
  logic [15:0]   rd2;
  logic [1:0]    gnt2;
  logic [W-1:0]  q2;
  logic          qv2;
  logic [0:0]    owner2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int qv_cnt = 0;
  bit rand_mode = 0;
  logic [NR-1:0] drop_mask = '0;

  int g_idx[$];
  int g_cyc[$];
  int g2_idx[$];
  int g2_cyc[$];

  // model: m_since = edges since the grant edge; > H1 means idle
  int         m_since = H1 + 1;
  int         m_ptr   = 0;
  int         m_owner = 0;
  logic [7:0] m_q     = '0;

  pipo_load_arbiter #(.N_REQ(NR), .WIDTH(W), .HOLD_CYCLES(H1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_gnt(gnt), .o_q(q), .o_q_valid(q_valid), .o_owner(owner)
  );

  pipo_load_arbiter #(.N_REQ(2), .WIDTH(W), .HOLD_CYCLES(1)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_req_valid(rv2), .i_req_data(rd2),
    .o_gnt(gnt2), .o_q(q2), .o_q_valid(qv2), .o_owner(owner2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [31:0] v);
    int r = -1;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_update();
    int w;
    if (rst) begin
      m_since = H1 + 1; m_ptr = 0; m_owner = 0; m_q = '0;
    end else if (m_since == 0) begin
      m_q = req_data[m_owner*W +: W];
      m_since = 1;
    end else if (m_since <= H1) begin
      m_since++;
    end else if (req_valid != '0) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      m_owner = w;
      m_ptr   = (w + 1) % NR;
      m_since = 0;
    end
  endtask

  task automatic step();
    logic [31:0] e_gnt;
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    e_gnt = (m_since == 0) ? (32'd1 << m_owner) : 32'd0;
    chk("gnt",     32'(gnt),     e_gnt);
    chk("q",       32'(q),       32'(m_q));
    chk("q_valid", 32'(q_valid), 32'((m_since >= 1) && (m_since <= H1)));
    chk("owner",   32'(owner),   32'(m_owner));
    if (q_valid) qv_cnt++;
    if (gnt != '0) begin g_idx.push_back(onehot_idx(32'(gnt))); g_cyc.push_back(cyc); end
    if (gnt2 != '0) begin g2_idx.push_back(onehot_idx(32'(gnt2))); g2_cyc.push_back(cyc); end
    // requesters drop (or re-arm) the cycle after their grant was seen
    for (int i = 0; i < NR; i++) begin
      if (drop_mask[i]) begin
        req_valid[i] = 1'b0;
        if (rand_mode && $urandom_range(1) == 1) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
      end else if (rand_mode && !req_valid[i] && $urandom_range(2) == 0) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = W'($urandom);
      end
    end
    drop_mask = gnt;
    if (rand_mode) rst = ($urandom_range(39) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '0;
    drop_mask = '0;
    g_idx.delete(); g_cyc.delete();
    qv_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    req_valid = '0; req_data = '0;
    rv2 = 2'b11; rd2 = 16'h2211;
    step(); step();
    rst2 = 1'b0;
    do_reset();
    chk("rst_q",     32'(q),       32'h0);
    chk("rst_gnt",   32'(gnt),     32'h0);
    chk("rst_qv",    32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner),   32'h0);

    // single request
    req_data[7:0] = 8'hCC; req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) step();
    chk("a_ngnt",   32'(g_idx.size()), 32'd1);
    chk("a_idx",    32'(g_idx[0]),     32'd0);
    chk("a_qvlen",  32'(qv_cnt),       32'd3);
    chk("a_retain", 32'(q),            32'hCC);

    // all four requesting
    do_reset();
    req_data = 32'hDDCCBBAA; req_valid = 4'b1111;
    for (int i = 0; i < 24; i++) step();
    chk("b_ngnt", 32'(g_idx.size()), 32'd4);
    for (int k = 0; k < g_idx.size() && k < 4; k++) begin
      chk("b_order", 32'(g_idx[k]), 32'(k));
      if (k > 0) chk("b_gap", 32'(g_cyc[k] - g_cyc[k-1]), 32'd5);
    end
    chk("b_lastq", 32'(q), 32'hDD);

    // pointer wrap: 2 wins, then 1 and 3 together -> 3 then 1
    do_reset();
    req_data = 32'h44332211; req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) step();
    req_valid = 4'b1010;
    for (int i = 0; i < 14; i++) step();
    chk("c_ngnt", 32'(g_idx.size()), 32'd3);
    chk("c_g0",   32'(g_idx[0]), 32'd2);
    chk("c_g1",   32'(g_idx[1]), 32'd3);
    chk("c_g2",   32'(g_idx[2]), 32'd1);

    // request arriving mid-HOLD waits for IDLE
    do_reset();
    req_data = 32'h00005A3C; req_valid = 4'b0001;
    step(); step();
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("d_ngnt", 32'(g_idx.size()), 32'd2);
    chk("d_g1",   32'(g_idx[1]), 32'd1);
    chk("d_gap",  32'(g_cyc[1] - g_cyc[0]), 32'd5);
    chk("d_qvlen", 32'(qv_cnt), 32'd6);

    // reset during HOLD
    do_reset();
    req_data = 32'h000011AA; req_valid = 4'b0001;
    step(); step(); step();
    chk("e_qhold", 32'(q), 32'hAA);
    chk("e_qv",    32'(q_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("e_q",     32'(q),       32'h0);
    chk("e_qv0",   32'(q_valid), 32'h0);
    chk("e_gnt",   32'(gnt),     32'h0);
    chk("e_owner", 32'(owner),   32'h0);
    g_idx.delete(); g_cyc.delete();
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) step();
    chk("e_first", 32'(g_idx[0]), 32'd0);

    // randomized traffic with occasional resets
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 800; i++) step();
    rand_mode = 0; rst = 1'b0;

    // second instance: N_REQ=2, HOLD_CYCLES=1, both requesting continuously
    chk("f_ngnt_ge8", 32'(g2_idx.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < g2_idx.size(); k++) begin
      chk("f_alt", 32'(g2_idx[k]), 32'(k % 2));
      if (k > 0) chk("f_gap", 32'(g2_cyc[k] - g2_cyc[k-1]), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
